// File: rtl/sound_pkg.sv
// Shared definitions for the sound card output path: ramp state encoding,
// default sample width and midscale/full-scale helpers.
package sound_pkg;

    localparam int SAMPLE_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        PLAY      = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_e;

    function automatic int mid_of(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int max_of(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/audio_ramp.sv
// Next-level / next-state logic for the anti-pop ramp. Purely combinational;
// the top level applies the result only at a PWM period boundary.
module audio_ramp
    import sound_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEFAULT,
    parameter int RAMP_STEP = 1
) (
    input  ramp_state_e         state_i,
    input  logic [SAMPLE_W-1:0] level_i,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    output ramp_state_e         state_o,
    output logic [SAMPLE_W-1:0] level_o,
    output logic                capture
);

    localparam int            W1       = SAMPLE_W + 1;
    localparam logic [W1-1:0] MID_EXT  = W1'(mid_of(SAMPLE_W));
    localparam logic [W1-1:0] STEP_EXT = W1'(RAMP_STEP);

    logic [W1-1:0] level_ext;
    logic [W1-1:0] up_sum;
    logic [W1-1:0] down_clamped;
    logic [W1-1:0] toward_mid;

    // One extra bit of headroom so level + step cannot wrap before clamping.
    always_comb begin
        level_ext    = {1'b0, level_i};
        up_sum       = level_ext + STEP_EXT;
        down_clamped = (level_ext < STEP_EXT) ? '0 : (level_ext - STEP_EXT);
        if (level_ext < MID_EXT) begin
            toward_mid = (up_sum > MID_EXT) ? MID_EXT : up_sum;
        end else begin
            toward_mid = (down_clamped < MID_EXT) ? MID_EXT : down_clamped;
        end
    end

    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_o = state_i;
        level_o = level_i;
        capture = 1'b0;
        case (state_i)
            IDLE: begin
                level_o = '0;
                if (enable) state_o = RAMP_UP;
            end
            RAMP_UP: begin
                if (!enable) begin
                    state_o = RAMP_DOWN;
                end else begin
                    level_o = toward_mid[SAMPLE_W-1:0];
                    if (toward_mid == MID_EXT) state_o = PLAY;
                end
            end
            PLAY: begin
                if (enable) begin
                    level_o = sample_in;
                    capture = 1'b1;
                end else begin
                    state_o = RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                // Reaching zero wins over a re-asserted enable.
                level_o = down_clamped[SAMPLE_W-1:0];
                if (down_clamped == '0) state_o = IDLE;
                else if (enable)        state_o = RAMP_UP;
            end
        endcase
    end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output stage: period counter, duty register and comparator, with
// a pop-free ramp to and from midscale when playback is enabled or disabled.
module pwm_audio_out
    import sound_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEFAULT,
    parameter int RAMP_STEP = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                pwm_out,
    output logic                sample_tick,
    output logic                active
);

    localparam logic [SAMPLE_W-1:0] CNT_MAX = SAMPLE_W'(max_of(SAMPLE_W));

    logic [SAMPLE_W-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] level_q, level_d;
    ramp_state_e         state_q, state_d;
    logic                pwm_q, pwm_d;
    logic                active_q, active_d;

    logic [SAMPLE_W-1:0] ramp_level;
    ramp_state_e         ramp_state;
    logic                ramp_capture;
    logic                boundary;

    audio_ramp #(
        .SAMPLE_W  (SAMPLE_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .state_i   (state_q),
        .level_i   (level_q),
        .enable    (enable),
        .sample_in (sample_in),
        .state_o   (ramp_state),
        .level_o   (ramp_level),
        .capture   (ramp_capture)
    );

    // Duty and state only move on the last count of a period, so a new level
    // always starts cleanly at count zero.
    always_comb begin
        boundary = (cnt_q == CNT_MAX);
        cnt_d    = cnt_q + SAMPLE_W'(1);
        state_d  = boundary ? ramp_state : state_q;
        level_d  = boundary ? ramp_level : level_q;
        pwm_d    = (cnt_q < level_q);
        active_d = (state_q != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            level_q  <= '0;
            state_q  <= IDLE;
            pwm_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            state_q  <= state_d;
            pwm_q    <= pwm_d;
            active_q <= active_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign sample_tick = boundary & ramp_capture;
    assign active      = active_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Self-checking bench for pwm_audio_out: per-period duty, strobe and activity
// are compared against a period-level model of the ramp rules.
module tb_pwm_audio_out;

    localparam int PER    = 256;
    localparam int MID    = 128;
    localparam int STEP   = 32;
    localparam int S_IDLE = 0;
    localparam int S_UP   = 1;
    localparam int S_PLAY = 2;
    localparam int S_DOWN = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] sample_in = 8'h00;
    logic       pwm_out, sample_tick, active;

    logic       enable_slow = 1'b0;
    logic [7:0] sample_slow = 8'h80;
    logic       pwm_slow, tick_slow, active_slow;

    int checks   = 0;
    int failures = 0;

    // Period-level model: state/level in force during the current period.
    int m_state      = S_IDLE;
    int m_prev_state = S_IDLE;
    int m_level      = 0;

    always #5 clk = ~clk;

    pwm_audio_out #(.SAMPLE_W(8), .RAMP_STEP(STEP)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .sample_in   (sample_in),
        .pwm_out     (pwm_out),
        .sample_tick (sample_tick),
        .active      (active)
    );

    pwm_audio_out #(.SAMPLE_W(8), .RAMP_STEP(1)) dut_slow (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable_slow),
        .sample_in   (sample_slow),
        .pwm_out     (pwm_slow),
        .sample_tick (tick_slow),
        .active      (active_slow)
    );

    task automatic model_boundary(input logic en, input int smp);
        int nl;
        m_prev_state = m_state;
        case (m_state)
            S_IDLE: begin
                m_level = 0;
                if (en) m_state = S_UP;
            end
            S_UP: begin
                if (!en) begin
                    m_state = S_DOWN;
                end else begin
                    if (m_level < MID) nl = (m_level + STEP > MID) ? MID : m_level + STEP;
                    else               nl = (m_level - STEP < MID) ? MID : m_level - STEP;
                    m_level = nl;
                    if (nl == MID) m_state = S_PLAY;
                end
            end
            S_PLAY: begin
                if (en) m_level = smp;
                else    m_state = S_DOWN;
            end
            default: begin
                nl = (m_level - STEP < 0) ? 0 : m_level - STEP;
                m_level = nl;
                if (nl == 0)  m_state = S_IDLE;
                else if (en) m_state = S_UP;
            end
        endcase
    endtask

    // Entered just after the edge that starts a period (counter at zero).
    // Runs one full period and checks duty, strobe and activity against the model.
    task automatic do_period(input string name, input logic en, input logic [7:0] smp,
                             input bit glitch);
        int  highs   = 0;
        int  ticks   = 0;
        int  tick_at = -1;
        int  exp_act_prev;
        int  exp_act_now;
        bit  exp_tick;
        enable    = en;
        sample_in = smp;
        exp_act_prev = (m_prev_state != S_IDLE) ? 1 : 0;
        exp_act_now  = (m_state != S_IDLE) ? 1 : 0;
        exp_tick     = (m_state == S_PLAY) && en;
        checks++;
        if (active !== exp_act_prev[0]) begin
            failures++;
            $display("FAIL %s active_at_start: got %b expected %0d", name, active, exp_act_prev);
        end
        for (int i = 1; i <= PER; i++) begin
            @(posedge clk); #1;
            if (glitch && i == 100) enable = ~en;
            if (glitch && i == 110) enable = en;
            if (pwm_out === 1'b1) highs++;
            if (sample_tick === 1'b1) begin
                ticks++;
                tick_at = i;
            end
            if (i == 1) begin
                checks++;
                if (active !== exp_act_now[0]) begin
                    failures++;
                    $display("FAIL %s active: got %b expected %0d", name, active, exp_act_now);
                end
            end
        end
        checks++;
        if (highs != m_level) begin
            failures++;
            $display("FAIL %s duty: got %0d high clocks expected %0d", name, highs, m_level);
        end
        checks++;
        if (exp_tick && (ticks != 1 || tick_at != PER - 1)) begin
            failures++;
            $display("FAIL %s sample_tick: got %0d ticks at clock %0d expected 1 at %0d",
                     name, ticks, tick_at, PER - 1);
        end else if (!exp_tick && ticks != 0) begin
            failures++;
            $display("FAIL %s sample_tick: got %0d ticks expected 0", name, ticks);
        end
        model_boundary(en, int'(smp));
    endtask

    task automatic apply_reset(input string name);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 1'b0 || active !== 1'b0 || sample_tick !== 1'b0) begin
            failures++;
            $display("FAIL %s reset_outputs: got pwm=%b active=%b tick=%b expected 0 0 0",
                     name, pwm_out, active, sample_tick);
        end
        @(posedge clk); #1;
        reset_n      = 1'b1;
        m_state      = S_IDLE;
        m_prev_state = S_IDLE;
        m_level      = 0;
    endtask

    task automatic test_idle();
        apply_reset("idle");
        for (int p = 0; p < 4; p++) do_period("idle", 1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic test_ramp_up();
        apply_reset("ramp_up");
        for (int p = 0; p < 6; p++) do_period("ramp_up", 1'b1, 8'hC0, 1'b0);
    endtask

    task automatic test_play_duty();
        do_period("play_c0", 1'b1, 8'h00, 1'b0);
        do_period("play_00", 1'b1, 8'hFF, 1'b0);
        do_period("play_ff", 1'b1, 8'h50, 1'b0);
    endtask

    task automatic test_ramp_down();
        for (int p = 0; p < 5; p++) do_period("ramp_down", 1'b0, 8'hAA, 1'b0);
        do_period("idle_after_down", 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reenable();
        for (int p = 0; p < 6; p++) do_period("reen_up", 1'b1, 8'h50, 1'b0);
        do_period("reen_drop", 1'b0, 8'h50, 1'b0);
        do_period("reen_back", 1'b1, 8'h50, 1'b0);
        for (int p = 0; p < 4; p++) do_period("reen_ramp", 1'b1, 8'h99, p[0]);
        do_period("reen_play", 1'b1, 8'h40, 1'b0);
    endtask

    task automatic test_glitch();
        do_period("glitch_play", 1'b1, 8'h20, 1'b1);
        for (int p = 0; p < 5; p++) do_period("glitch_down", 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid_play();
        apply_reset("mid_reset_pre");
        for (int p = 0; p < 6; p++) do_period("mid_reset_up", 1'b1, 8'hC0, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (pwm_out !== 1'b1 || active !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_before: got pwm=%b active=%b expected 1 1", pwm_out, active);
        end
        apply_reset("mid_reset");
        for (int p = 0; p < 3; p++) do_period("after_reset", 1'b1, 8'hE0, 1'b0);
    endtask

    task automatic test_random();
        apply_reset("random");
        for (int p = 0; p < 24; p++) begin
            do_period("random", ($urandom_range(0, 3) != 0), 8'($urandom),
                      ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_slow_ramp();
        int first_tick = -1;
        int main_highs = 0;
        int expected   = PER * (1 + MID + 1) - 1;
        enable = 1'b0;
        apply_reset("slow");
        enable_slow = 1'b1;
        for (int c = 1; c <= expected + PER && first_tick < 0; c++) begin
            @(posedge clk); #1;
            if (tick_slow === 1'b1) first_tick = c;
            if (pwm_out === 1'b1 || sample_tick === 1'b1) main_highs++;
        end
        checks++;
        if (first_tick != expected) begin
            failures++;
            $display("FAIL slow_ramp first_tick: got clock %0d expected %0d", first_tick, expected);
        end
        checks++;
        if (active_slow !== 1'b1) begin
            failures++;
            $display("FAIL slow_ramp active: got %b expected 1", active_slow);
        end
        checks++;
        if (main_highs != 0) begin
            failures++;
            $display("FAIL slow_ramp idle_neighbour: got %0d events expected 0", main_highs);
        end
        enable_slow = 1'b0;
    endtask

    initial begin
        test_idle();
        test_ramp_up();
        test_play_duty();
        test_ramp_down();
        test_reenable();
        test_glitch();
        test_reset_mid_play();
        test_random();
        test_slow_ramp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
